// File: rtl/pmips_pkg.sv
// pmips_pkg: shared widths, forward-select encoding and register-match helper for the pmips core.
package pmips_pkg;
  localparam int DW  = 16;
  localparam int IW  = 17;
  localparam int RAW = 3;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  // Register 0 is hard-wired to zero when zero_hard is set, so it never aliases a producer.
  function automatic logic reg_match(input logic [31:0] d, input logic [31:0] s, input logic zero_hard);
    return (d == s) && !(zero_hard && d == 32'd0);
  endfunction
endpackage

// File: rtl/pmips_sat_counter.sv
// pmips_sat_counter: event counter that sticks at all-ones.
module pmips_sat_counter #(
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] count
);
  logic [CW-1:0] count_q;
  assign count = count_q;
  always_ff @(posedge clock)
    count_q <= reset ? '0 : (inc && count_q != '1) ? count_q + CW'(1) : count_q;
endmodule

// File: rtl/pmips_fetch_hazard.sv
// pmips_fetch_hazard: PC and IF/ID register with load-use stall, MEM-stage redirect flush
// and registered EX operand-forwarding selects.
module pmips_fetch_hazard import pmips_pkg::*; #(
  parameter int DW        = pmips_pkg::DW,
  parameter int IW        = pmips_pkg::IW,
  parameter int RAW       = pmips_pkg::RAW,
  parameter int PC_INC    = 2,
  parameter int ZERO_HARD = 1,
  parameter int CW        = 16
) (
  input  logic           clock,
  input  logic           reset,
  output logic [DW-1:0]  imem_addr,
  input  logic [IW-1:0]  imem_rdata,
  output logic [IW-1:0]  ifid_instr,
  output logic [DW-1:0]  ifid_pcplus,
  output logic           ifid_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic [RAW-1:0] ex_dst,
  input  logic           ex_regwrite,
  input  logic           ex_memread,
  input  logic [RAW-1:0] mem_dst,
  input  logic           mem_regwrite,
  input  logic           redirect,
  input  logic [DW-1:0]  redirect_addr,
  output logic           stall,
  output logic           flush_idex,
  output logic           flush_exmem,
  output logic [1:0]     ex_fwd_a,
  output logic [1:0]     ex_fwd_b,
  output logic [CW-1:0]  stall_cnt,
  output logic [CW-1:0]  flush_cnt
);
  localparam logic ZH = (ZERO_HARD != 0);
  logic [DW-1:0] pc_q, pc_d, pcplus_q, pcplus_d, pc_inc;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, fwd_a_n, fwd_b_n;
  logic          ex_rs, ex_rt, mem_rs, mem_rt, hz;
  assign ex_rs  = reg_match(32'(ex_dst), 32'(id_rs), ZH);
  assign ex_rt  = reg_match(32'(ex_dst), 32'(id_rt), ZH);
  assign mem_rs = reg_match(32'(mem_dst), 32'(id_rs), ZH);
  assign mem_rt = reg_match(32'(mem_dst), 32'(id_rt), ZH);
  assign hz = valid_q && ex_regwrite && ex_memread && ((id_use_rs && ex_rs) || (id_use_rt && ex_rt));
  assign stall       = hz && !redirect;
  assign flush_idex  = stall || redirect;
  assign flush_exmem = redirect;
  assign pc_inc = pc_q + DW'(PC_INC);
  // EX producer wins over MEM: it holds the younger value of the register.
  assign fwd_a_n = !(valid_q && id_use_rs) ? FWD_RF :
                   (ex_regwrite && ex_rs)   ? FWD_EXMEM :
                   (mem_regwrite && mem_rs) ? FWD_MEMWB : FWD_RF;
  assign fwd_b_n = !(valid_q && id_use_rt) ? FWD_RF :
                   (ex_regwrite && ex_rt)   ? FWD_EXMEM :
                   (mem_regwrite && mem_rt) ? FWD_MEMWB : FWD_RF;
  always_comb begin
    pc_d     = pc_inc;
    instr_d  = imem_rdata;
    pcplus_d = pc_inc;
    valid_d  = 1'b1;
    fwd_a_d  = fwd_a_n;
    fwd_b_d  = fwd_b_n;
    if (redirect) begin
      pc_d     = redirect_addr;
      instr_d  = '0;
      pcplus_d = pcplus_q;
      valid_d  = 1'b0;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
    end else if (stall) begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      pcplus_d = pcplus_q;
      valid_d  = valid_q;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      pcplus_q <= '0;
      valid_q  <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcplus_q <= pcplus_d;
      valid_q  <= valid_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end
  assign imem_addr   = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pcplus = pcplus_q;
  assign ifid_valid  = valid_q;
  assign ex_fwd_a    = fwd_a_q;
  assign ex_fwd_b    = fwd_b_q;
  pmips_sat_counter #(.CW(CW)) u_stall_cnt (.clock(clock), .reset(reset), .inc(stall),    .count(stall_cnt));
  pmips_sat_counter #(.CW(CW)) u_flush_cnt (.clock(clock), .reset(reset), .inc(redirect), .count(flush_cnt));
endmodule

// File: tb/tb_pmips_fetch_hazard.sv
// tb_pmips_fetch_hazard: directed and random stimulus against a behavioural pipeline-control model.
module tb_pmips_fetch_hazard;
  localparam int DW = 16, IW = 17, RAW = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clock = 1'b0, reset;
  logic [DW-1:0] imem_addr, ifid_pcplus, redirect_addr;
  logic [IW-1:0] imem_rdata, ifid_instr;
  logic ifid_valid, id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite, redirect;
  logic [RAW-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic stall, flush_idex, flush_exmem;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  always #5 clock = ~clock;

  pmips_fetch_hazard #(.DW(DW), .IW(IW), .RAW(RAW), .PC_INC(2), .ZERO_HARD(1), .CW(CW)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pcplus(ifid_pcplus), .ifid_valid(ifid_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .redirect(redirect),
    .redirect_addr(redirect_addr), .stall(stall), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model of the fetch stage and hazard rules.
  logic [DW-1:0] m_pc, m_pcplus;
  logic [IW-1:0] m_instr;
  logic m_valid, m_stall;
  logic [1:0] m_fa, m_fb;
  int m_sc, m_fc;

  function automatic bit mm(input logic [RAW-1:0] d, input logic [RAW-1:0] s);
    return d == s && d != 0;
  endfunction

  function automatic logic [1:0] msel(input bit v, input logic u, input logic [RAW-1:0] s,
                                      input logic exw, input logic [RAW-1:0] exd,
                                      input logic mw, input logic [RAW-1:0] md);
    if (!v || !u) return 2'd0;
    if (exw && mm(exd, s)) return 2'd1;
    if (mw && mm(md, s)) return 2'd2;
    return 2'd0;
  endfunction

  assign m_stall = !redirect && m_valid && ex_regwrite && ex_memread &&
                   ((id_use_rs && mm(ex_dst, id_rs)) || (id_use_rt && mm(ex_dst, id_rt)));

  always @(posedge clock) begin
    if (reset) begin
      m_pc <= 0; m_pcplus <= 0; m_instr <= 0; m_valid <= 0; m_fa <= 0; m_fb <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      if (redirect) begin
        m_pc <= redirect_addr; m_valid <= 0; m_instr <= 0; m_fa <= 0; m_fb <= 0;
      end else if (m_stall) begin
        m_fa <= 0; m_fb <= 0;
      end else begin
        m_pc <= m_pc + 16'd2; m_pcplus <= m_pc + 16'd2; m_instr <= imem_rdata; m_valid <= 1;
        m_fa <= msel(m_valid, id_use_rs, id_rs, ex_regwrite, ex_dst, mem_regwrite, mem_dst);
        m_fb <= msel(m_valid, id_use_rt, id_rt, ex_regwrite, ex_dst, mem_regwrite, mem_dst);
      end
      if (m_stall && m_sc < CMAX) m_sc <= m_sc + 1;
      if (redirect && m_fc < CMAX) m_fc <= m_fc + 1;
    end
  end

  always @(negedge clock) if (chk_on) begin
    chk("imem_addr", imem_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pcplus", ifid_pcplus, m_pcplus);
    chk("ifid_valid", ifid_valid, m_valid);
    chk("stall", stall, m_stall);
    chk("flush_idex", flush_idex, m_stall || redirect);
    chk("flush_exmem", flush_exmem, redirect);
    chk("ex_fwd_a", ex_fwd_a, m_fa);
    chk("ex_fwd_b", ex_fwd_b, m_fb);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; ex_dst = 0; ex_regwrite = 0;
    ex_memread = 0; mem_dst = 0; mem_regwrite = 0; redirect = 0; redirect_addr = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hazard3();
    ex_memread = 1; ex_regwrite = 1; ex_dst = 3; id_rs = 3; id_use_rs = 1;
  endtask

  initial begin
    clr();
    imem_rdata = 0;
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk_on = 1;
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt}, 0);
    for (int i = 1; i <= 3; i++) begin
      imem_rdata = IW'(i);
      tick();
      chk("run_addr", imem_addr, 2 * i);
      chk("run_instr", ifid_instr, i);
      chk("run_valid", ifid_valid, 1);
      chk("run_flush", {stall, flush_idex, flush_exmem}, 0);
    end
    hazard3();
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_flush", {flush_idex, flush_exmem}, 2'b10);
    tick();
    chk("lu_hold_pc", imem_addr, 6);
    chk("lu_hold_ir", ifid_instr, 3);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_bubble", ex_fwd_a, 0);
    clr();
    id_rs = 3; id_use_rs = 1; mem_regwrite = 1; mem_dst = 3;
    #1;
    chk("lu2_stall", stall, 0);
    tick();
    chk("lu2_fwd", ex_fwd_a, 2);
    chk("lu2_pc", imem_addr, 8);
    clr();
    ex_dst = 2; mem_dst = 2; ex_regwrite = 1; mem_regwrite = 1; id_rt = 2; id_use_rt = 1;
    #1;
    chk("dbl_stall", stall, 0);
    tick();
    chk("dbl_fwd", ex_fwd_b, 1);
    clr();
    ex_memread = 1; ex_regwrite = 1; id_use_rs = 1;
    #1;
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_fwd", ex_fwd_a, 0);
    clr();
    hazard3();
    redirect = 1; redirect_addr = 16'h0040;
    #1;
    chk("rd_flush", {stall, flush_idex, flush_exmem}, 3'b011);
    tick();
    chk("rd_addr", imem_addr, 16'h0040);
    chk("rd_valid", ifid_valid, 0);
    chk("rd_cnt", flush_cnt, 1);
    clr();
    tick();
    chk("rd2_valid", ifid_valid, 1);
    chk("rd2_pcplus", ifid_pcplus, 16'h0042);
    redirect = 1; redirect_addr = 16'hFFFE;
    tick();
    redirect = 0;
    tick();
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_pcplus", ifid_pcplus, 0);
    hazard3();
    repeat ((1 << CW) + 3) tick();
    chk("sat_cnt", stall_cnt, 4'hF);
    chk("sat_stall", stall, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst2_state", {imem_addr, ifid_pcplus, ifid_valid}, 0);
    chk("rst2_ir", ifid_instr, 0);
    chk("rst2_misc", {ex_fwd_a, ex_fwd_b, stall_cnt, flush_cnt}, 0);
    chk("rst2_stall", stall, 0);
    clr();
    for (int i = 0; i < 3000; i++) begin
      imem_rdata = IW'($urandom);
      id_rs = RAW'($urandom); id_rt = RAW'($urandom);
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      ex_dst = RAW'($urandom); mem_dst = RAW'($urandom);
      ex_regwrite = 1'($urandom); mem_regwrite = 1'($urandom);
      ex_memread = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 11) == 0);
      redirect_addr = DW'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0;
    clr();
    tick();
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
